digit_feature_encoder: RTL and testbench

//  Inverse of the digit perceptron classifier: accepts a decimal digit and emits its
//  (edges, curves) feature signature as two serial pulse trains (edge_pulse, curve_pulse).

---
 rtl/perceptron_pkg.sv | 41 ++++
 rtl/pulse_spacer.sv | 69 ++++++
 rtl/digit_feature_encoder.sv | 113 +++++++++++
 tb/tb_digit_feature_encoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared widths, FSM states and the digit feature table
//
// Purpose: the one place the digit -> (edges, curves) signature lives, so the
//          encoder and anything else built around the perceptron agree on it.
// Ports:   none (package).
package perceptron_pkg;

   localparam int EDGE_W  = 3;
   localparam int CURVE_W = 4;
   localparam int DIGIT_W = 4;

   typedef enum logic [2:0] {IDLE, EDGES, CURVES, FIN, ERR} state_t;

   typedef struct packed {
      logic               legal;
      logic [EDGE_W-1:0]  edges;
      logic [CURVE_W-1:0] curves;
   } features_t;

   function automatic features_t digit_features(input logic [DIGIT_W-1:0] digit);
      features_t f;
      f.legal  = 1'b1;
      f.edges  = '0;
      f.curves = '0;
      case (digit)
         4'd0:    f.curves = 4'd4;
         4'd1:    f.edges  = 3'd1;
         4'd2:    begin f.edges = 3'd1; f.curves = 4'd2; end
         4'd3:    f.curves = 4'd6;
         4'd4:    f.edges  = 3'd3;
         4'd5:    begin f.edges = 3'd2; f.curves = 4'd2; end
         4'd6:    f.curves = 4'd5;
         4'd7:    f.edges  = 3'd2;
         4'd8:    f.curves = 4'd8;
         4'd9:    begin f.edges = 3'd1; f.curves = 4'd3; end
         default: f.legal  = 1'b0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/pulse_spacer.sv
// rtl/pulse_spacer.sv - emits N one-cycle pulses, each followed by GAP low cycles
//
// Purpose: generic pulse train generator, reloaded once per feature phase.
// Ports:   clk, rst_n  clock, async active-low reset
//          load        start a new train (overrides one in progress)
//          count       number of pulses for the new train (0 = nothing)
//          pulse       registered pulse output
//          last        high during the final cycle of the train (pulse or gap)
module pulse_spacer #(
   parameter int GAP = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] count,
   output logic       pulse,
   output logic       last
);

   localparam logic [2:0] GAP_L = 3'(GAP);

   logic       active_q;
   logic       pulse_q;
   logic [3:0] rem_q;   // pulses still to come after the current one
   logic [2:0] gap_q;   // gap cycles left, including the current gap cycle

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         pulse_q  <= 1'b0;
         rem_q    <= '0;
         gap_q    <= '0;
      end else if (load) begin
         active_q <= (count != 4'd0);
         pulse_q  <= (count != 4'd0);
         rem_q    <= (count != 4'd0) ? count - 4'd1 : 4'd0;
         gap_q    <= GAP_L;
      end else if (active_q) begin
         if (pulse_q) begin
            if (GAP_L == 3'd0) begin
               // back-to-back: stay high until the last pulse is out
               if (rem_q != 4'd0) begin
                  rem_q <= rem_q - 4'd1;
               end else begin
                  active_q <= 1'b0;
                  pulse_q  <= 1'b0;
               end
            end else begin
               pulse_q <= 1'b0;
               gap_q   <= GAP_L;
            end
         end else if (gap_q == 3'd1) begin
            if (rem_q != 4'd0) begin
               pulse_q <= 1'b1;
               rem_q   <= rem_q - 4'd1;
            end else begin
               active_q <= 1'b0;
            end
         end else begin
            gap_q <= gap_q - 3'd1;
         end
      end
   end

   assign pulse = pulse_q;
   assign last  = active_q && (rem_q == 4'd0) &&
                  (pulse_q ? (GAP_L == 3'd0) : (gap_q == 3'd1));

endmodule

// File: rtl/digit_feature_encoder.sv
// rtl/digit_feature_encoder.sv - encodes a digit as serial edge/curve pulse trains
//
// Purpose: accepts a digit, emits its edge pulses then its curve pulses, then
//          a done strobe; illegal digits give a single err strobe instead.
// Ports:   clk, rst_n            clock, async active-low reset
//          in_valid/in_ready     digit handshake (ready only when idle)
//          in_digit              digit to encode, sampled at accept
//          edge_pulse            one pulse per edge feature
//          curve_pulse           one pulse per curve feature
//          feat_edges/curves     held counts of the last legal digit
//          busy, done, err       sequence status and strobes
module digit_feature_encoder
   import perceptron_pkg::*;
#(
   parameter int GAP = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DIGIT_W-1:0] in_digit,
   output logic               edge_pulse,
   output logic               curve_pulse,
   output logic [EDGE_W-1:0]  feat_edges,
   output logic [CURVE_W-1:0] feat_curves,
   output logic               busy,
   output logic               done,
   output logic               err
);

   state_t     state_q, state_d;
   features_t  acc_f;
   logic       accept;
   logic       sp_load;
   logic [3:0] sp_count;
   logic       sp_pulse;
   logic       sp_last;

   assign acc_f  = digit_features(in_digit);
   assign accept = in_valid && (state_q == IDLE);

   pulse_spacer #(.GAP(GAP)) u_spacer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (sp_load),
      .count (sp_count),
      .pulse (sp_pulse),
      .last  (sp_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         feat_edges  <= '0;
         feat_curves <= '0;
      end else begin
         state_q <= state_d;
         if (accept && acc_f.legal) begin
            feat_edges  <= acc_f.edges;
            feat_curves <= acc_f.curves;
         end
      end
   end

   // Zero-count phases are skipped by loading the next phase directly.
   always_comb begin
      state_d  = state_q;
      sp_load  = 1'b0;
      sp_count = '0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (!acc_f.legal) begin
                  state_d = ERR;
               end else if (acc_f.edges != '0) begin
                  sp_load  = 1'b1;
                  sp_count = {1'b0, acc_f.edges};
                  state_d  = EDGES;
               end else if (acc_f.curves != '0) begin
                  sp_load  = 1'b1;
                  sp_count = acc_f.curves;
                  state_d  = CURVES;
               end else begin
                  state_d = FIN;
               end
            end
         end
         EDGES: begin
            if (sp_last) begin
               if (feat_curves != '0) begin
                  sp_load  = 1'b1;
                  sp_count = feat_curves;
                  state_d  = CURVES;
               end else begin
                  state_d = FIN;
               end
            end
         end
         CURVES:  if (sp_last) state_d = FIN;
         FIN:     state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_ready    = (state_q == IDLE);
   assign busy        = (state_q == EDGES) || (state_q == CURVES) || (state_q == FIN);
   assign done        = (state_q == FIN);
   assign err         = (state_q == ERR);
   assign edge_pulse  = sp_pulse && (state_q == EDGES);
   assign curve_pulse = sp_pulse && (state_q == CURVES);

endmodule

// File: tb/tb_digit_feature_encoder.sv
// tb/tb_digit_feature_encoder.sv - directed vectors for digit_feature_encoder
module tb_digit_feature_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       v1, v0;
   logic [3:0] d1, d0;
   logic       r1, ep1, cp1, b1, dn1, er1;
   logic       r0, ep0, cp0, b0, dn0, er0;
   logic [2:0] fe1, fe0;
   logic [3:0] fc1, fc0;

   digit_feature_encoder #(.GAP(1)) u_g1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_digit(d1),
      .edge_pulse(ep1), .curve_pulse(cp1), .feat_edges(fe1), .feat_curves(fc1),
      .busy(b1), .done(dn1), .err(er1)
   );

   digit_feature_encoder #(.GAP(0)) u_g0 (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .in_digit(d0),
      .edge_pulse(ep0), .curve_pulse(cp0), .feat_edges(fe0), .feat_curves(fc0),
      .busy(b0), .done(dn0), .err(er0)
   );

   typedef struct {
      int         g;
      logic [3:0] digit;
      int         e;
      int         c;
      bit         legal;
   } vec_t;

   typedef struct packed {
      logic       rdy, ep, cp, bz, dn, er;
      logic [2:0] fe;
      logic [3:0] fc;
   } outs_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   last_e[2];
   int   last_c[2];
   vec_t vecs[11];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic outs_t get_outs(input int g);
      outs_t o;
      if (g == 1) begin
         o.rdy = r1; o.ep = ep1; o.cp = cp1; o.bz = b1; o.dn = dn1; o.er = er1;
         o.fe = fe1; o.fc = fc1;
      end else begin
         o.rdy = r0; o.ep = ep0; o.cp = cp0; o.bz = b0; o.dn = dn0; o.er = er0;
         o.fe = fe0; o.fc = fc0;
      end
      return o;
   endfunction

   task automatic drive(input int g, input logic v, input logic [3:0] d);
      if (g == 1) begin v1 = v; d1 = d; end
      else begin v0 = v; d0 = d; end
   endtask

   // Accept one digit, then compare every output at each offset after accept
   // against the expected pulse schedule until in_ready returns.
   task automatic apply(input vec_t v);
      outs_t o;
      int    per, done_off, win, bad_off, idx, wait_n;
      bit    ee, ec, ed, er, eb, erd;
      wait_n = 0;
      @(negedge clk);
      while (!get_outs(v.g).rdy && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      check($sformatf("ready_before_g%0d_d%0d", v.g, v.digit), int'(get_outs(v.g).rdy), 1);
      drive(v.g, 1'b1, v.digit);
      @(posedge clk);
      @(negedge clk);
      drive(v.g, 1'b0, 4'd0);
      per      = 1 + v.g;
      done_off = 1 + (v.e + v.c) * per;
      win      = v.legal ? done_off + 1 : 2;
      bad_off  = 0;
      for (int off = 1; off <= win; off++) begin
         if (off > 1) @(negedge clk);
         o = get_outs(v.g);
         if (off == 1) begin
            check($sformatf("feat_edges_g%0d_d%0d", v.g, v.digit), int'(o.fe),
                  v.legal ? v.e : last_e[v.g]);
            check($sformatf("feat_curves_g%0d_d%0d", v.g, v.digit), int'(o.fc),
                  v.legal ? v.c : last_c[v.g]);
         end
         idx = (off - 1) / per;
         ee  = v.legal && ((off - 1) % per == 0) && (idx < v.e);
         ec  = v.legal && ((off - 1) % per == 0) && (idx >= v.e) && (idx < v.e + v.c);
         ed  = v.legal && (off == done_off);
         er  = !v.legal && (off == 1);
         eb  = v.legal && (off <= done_off);
         erd = v.legal ? (off > done_off) : (off > 1);
         if ({o.ep, o.cp, o.dn, o.er, o.bz, o.rdy} != {ee, ec, ed, er, eb, erd} && bad_off == 0)
            bad_off = off;
      end
      check($sformatf("schedule_g%0d_d%0d_first_bad_offset", v.g, v.digit), bad_off, 0);
      if (v.legal) begin
         last_e[v.g] = v.e;
         last_c[v.g] = v.c;
      end
   endtask

   initial begin
      int eq[$];
      int dq[$];
      int exp_eq[3];
      int exp_dq[2];
      int n_cp, acc2, n_dn, wait_n;
      bit drop;
      outs_t o;

      vecs[0]  = '{1, 4'd5,  2, 2, 1'b1};
      vecs[1]  = '{1, 4'd8,  0, 8, 1'b1};
      vecs[2]  = '{1, 4'd12, 0, 0, 1'b0};
      vecs[3]  = '{0, 4'd4,  3, 0, 1'b1};
      vecs[4]  = '{0, 4'd6,  0, 5, 1'b1};
      vecs[5]  = '{0, 4'd10, 0, 0, 1'b0};
      vecs[6]  = '{1, 4'd0,  0, 4, 1'b1};
      vecs[7]  = '{1, 4'd3,  0, 6, 1'b1};
      vecs[8]  = '{0, 4'd9,  1, 3, 1'b1};
      vecs[9]  = '{1, 4'd15, 0, 0, 1'b0};
      vecs[10] = '{0, 4'd2,  1, 2, 1'b1};
      last_e = '{0, 0};
      last_c = '{0, 0};

      rst_n = 1'b0;
      v1 = 1'b0; v0 = 1'b0; d1 = 4'd0; d0 = 4'd0;
      #12;
      for (int g = 0; g < 2; g++) begin
         o = get_outs(g);
         check($sformatf("reset_ready_g%0d", g), int'(o.rdy), 1);
         check($sformatf("reset_quiet_g%0d", g),
               int'({o.ep, o.cp, o.bz, o.dn, o.er, o.fe, o.fc}), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) apply(vecs[i]);

      // in_valid held high across digit 1 then digit 7 (GAP=1)
      @(negedge clk);
      wait_n = 0;
      while (!r1 && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      drive(1, 1'b1, 4'd1);
      @(posedge clk);
      @(negedge clk);
      d1   = 4'd7;
      n_cp = 0;
      acc2 = 0;
      drop = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) @(negedge clk);
         if (drop) begin
            v1   = 1'b0;
            drop = 1'b0;
         end
         if (ep1) eq.push_back(k);
         if (dn1) dq.push_back(k);
         if (cp1) n_cp++;
         if (r1 && v1) begin
            acc2 = k;
            drop = 1'b1;
         end
      end
      exp_eq = '{1, 5, 7};
      exp_dq = '{3, 9};
      check("held_second_accept_offset", acc2, 4);
      check("held_edge_pulse_count", eq.size(), 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("held_edge_pulse_%0d_offset", i), (i < eq.size()) ? eq[i] : -1, exp_eq[i]);
      check("held_done_count", dq.size(), 2);
      for (int i = 0; i < 2; i++)
         check($sformatf("held_done_%0d_offset", i), (i < dq.size()) ? dq[i] : -1, exp_dq[i]);
      check("held_curve_pulses", n_cp, 0);
      check("held_feat_edges", int'(fe1), 2);
      last_e[1] = 2;
      last_c[1] = 0;

      // reset asserted while digit 9 is in its curve phase (GAP=1)
      @(negedge clk);
      drive(1, 1'b1, 4'd9);
      @(posedge clk);
      @(negedge clk);
      drive(1, 1'b0, 4'd0);
      @(negedge clk);
      @(negedge clk);
      check("d9_curve_pulse_before_reset", int'(cp1), 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_ready", int'(r1), 1);
      check("abort_quiet", int'({ep1, cp1, b1, dn1, er1, fe1, fc1}), 0);
      last_e = '{0, 0};
      last_c = '{0, 0};
      @(negedge clk);
      rst_n = 1'b1;
      n_dn = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (dn1 || ep1 || cp1) n_dn++;
      end
      check("abort_no_done_or_pulses", n_dn, 0);
      apply('{1, 4'd2, 1, 2, 1'b1});

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
